im_arb: RTL

IM_ARB -- requirements
Module: im_arb

---
 rtl/im_arb_pkg.sv | 20 ++
 rtl/im_arb_if.sv | 40 ++++
 rtl/im_rsp_skid.sv | 56 +++++
 rtl/im_arb.sv | 94 +++++++++
 4 files changed

// File: rtl/im_arb_pkg.sv
// ============================================================================
// Module : im_arb_pkg
// Brief  : Shared types and constants for the IF/LS instruction-memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package im_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LS   = 2'd2
    } gnt_t;

    localparam int STARVE_W = 4;

endpackage

`default_nettype wire

// File: rtl/im_arb_if.sv
// ============================================================================
// Module : im_arb_if
// Brief  : Request/response handshakes of the IF and LS ports of im_arb.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface im_arb_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_flush;
    logic              if_rsp_valid;
    logic              if_rsp_ready;
    logic [31:0]       if_rsp_data;
    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_req_addr;
    logic              ls_rsp_valid;
    logic              ls_rsp_ready;
    logic [31:0]       ls_rsp_data;

    modport master (
        output if_req_valid, if_req_addr, if_flush, if_rsp_ready,
        output ls_req_valid, ls_req_addr, ls_rsp_ready,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data
    );

    modport slave (
        input  if_req_valid, if_req_addr, if_flush, if_rsp_ready,
        input  ls_req_valid, ls_req_addr, ls_rsp_ready,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/im_rsp_skid.sv
// ============================================================================
// Module : im_rsp_skid
// Brief  : One-entry response skid buffer; fresh data passes straight through.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module im_rsp_skid (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        clr_i,
    input  wire logic        in_valid_i,
    input  wire logic [31:0] in_data_i,
    input  wire logic        out_ready_i,
    output logic             out_valid_o,
    output logic [31:0]      out_data_o,
    output logic             full_o
);
    logic        full_q, full_d;
    logic [31:0] data_q, data_d;

    assign out_valid_o = !clr_i && (full_q || in_valid_i);
    assign out_data_o  = full_q ? data_q : in_data_i;
    assign full_o      = full_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (full_q) begin
            if (out_ready_i) full_d = 1'b0;
        end else if (in_valid_i && !out_ready_i) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    // A fresh word arriving while the entry is occupied would be lost.
    always @(posedge clk) begin
        if (rst_n && !clr_i) assert (!(full_q && in_valid_i));
    end

endmodule

`default_nettype wire

// File: rtl/im_arb.sv
// ============================================================================
// Module : im_arb
// Brief  : Arbitrates IF fetches and LS reads onto one IM read port (LS first, anti-starvation).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module im_arb #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    im_arb_if.slave                bus,
    output logic                   IM_en,
    output logic [ADDR_W-1:0]      IM_r_addr,
    input  wire logic [31:0]       IM_r_data
);
    import im_arb_pkg::*;

    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);

    gnt_t                gnt_q, gnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                w_if_full, w_ls_full;
    logic                w_if_elig, w_ls_elig;

    // A full buffer that drains this cycle counts as free, so a new grant can overlap the drain.
    assign w_if_elig = bus.if_req_valid && (!w_if_full || bus.if_rsp_ready)
                       && (gnt_q != GNT_IF || bus.if_rsp_ready);
    assign w_ls_elig = bus.ls_req_valid && (!w_ls_full || bus.ls_rsp_ready)
                       && (gnt_q != GNT_LS || bus.ls_rsp_ready);

    always_comb begin
        gnt_d    = GNT_NONE;
        starve_d = '0;
        if (rst_n) begin
            if (w_ls_elig && !(w_if_elig && starve_q == C_STARVE_MAX)) gnt_d = GNT_LS;
            else if (w_if_elig)                                        gnt_d = GNT_IF;
        end
        if (gnt_d == GNT_LS && w_if_elig)
            starve_d = (starve_q == C_STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= GNT_NONE;
            starve_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            starve_q <= starve_d;
        end
    end

    assign bus.if_req_ready = (gnt_d == GNT_IF);
    assign bus.ls_req_ready = (gnt_d == GNT_LS);
    assign IM_en            = (gnt_d != GNT_NONE);

    always_comb begin
        IM_r_addr = '0;
        case (gnt_d)
            GNT_IF:  IM_r_addr = bus.if_req_addr;
            GNT_LS:  IM_r_addr = bus.ls_req_addr;
            default: IM_r_addr = '0;
        endcase
    end

    im_rsp_skid u_if_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (bus.if_flush),
        .in_valid_i  (gnt_q == GNT_IF),
        .in_data_i   (IM_r_data),
        .out_ready_i (bus.if_rsp_ready),
        .out_valid_o (bus.if_rsp_valid),
        .out_data_o  (bus.if_rsp_data),
        .full_o      (w_if_full)
    );

    im_rsp_skid u_ls_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (1'b0),
        .in_valid_i  (gnt_q == GNT_LS),
        .in_data_i   (IM_r_data),
        .out_ready_i (bus.ls_rsp_ready),
        .out_valid_o (bus.ls_rsp_valid),
        .out_data_o  (bus.ls_rsp_data),
        .full_o      (w_ls_full)
    );

endmodule

`default_nettype wire
